// File: rtl/dnu_ctrl_pkg.sv
// dnu_ctrl_pkg: state and writer-status codes shared by the
// iteration-request initiator and the DNU write FSMs.
package dnu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_RQST    = 3'b001,
    S_HOLD    = 3'b010,
    S_RELEASE = 3'b011,
    S_DECODE  = 3'b100,
    S_TERM    = 3'b101,
    S_DONE    = 3'b110
  } state_t;

  localparam logic [1:0] BUSY_IDLE = 2'b00;
  localparam logic [1:0] BUSY_LOAD = 2'b01;
  localparam logic [1:0] BUSY_FIN  = 2'b10;
  localparam logic [1:0] BUSY_ILL  = 2'b11;

endpackage

// File: rtl/dnu_iter_rqst_fsm_if.sv
// dnu_iter_rqst_fsm_if: reload handshake between initiator (master)
// and writer (slave): iter_rqst, iter_termination out; wr_busy back.
interface dnu_iter_rqst_fsm_if;

  logic       iter_rqst;
  logic       iter_termination;
  logic [1:0] wr_busy;

  modport master (
    output iter_rqst,
    output iter_termination,
    input  wr_busy
  );

  modport slave (
    input  iter_rqst,
    input  iter_termination,
    output wr_busy
  );

endinterface

// File: rtl/hs_timeout_cnt.sv
// hs_timeout_cnt: clearable enabled counter; tc high at TIMEOUT-1.
// Ports: clk, rstn (sync, low), clr, en in; tc out.
module hs_timeout_cnt #(
  parameter int  TIMEOUT = 256,
  localparam int W       = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(TIMEOUT - 1));

  // Holds at terminal count so tc stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (!rstn)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !tc)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/dnu_iter_rqst_fsm.sv
// dnu_iter_rqst_fsm: per-iteration reload request, verdict wait and
// termination. Ports: sys_clk, rstn, decode/syndrome in; wr bus; status out.
module dnu_iter_rqst_fsm
  import dnu_ctrl_pkg::*;
#(
  parameter int  MAX_ITER = 10,
  parameter int  TIMEOUT  = 256,
  localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                sys_clk,
  input  logic                rstn,
  input  logic                decode_start,
  input  logic                syndrome_valid,
  input  logic                syndrome_pass,
  dnu_iter_rqst_fsm_if.master wr,
  output logic [ITER_W-1:0]   iter_cnt,
  output logic                decode_done,
  output logic                decode_fail,
  output logic                timeout_err,
  output logic [2:0]          state
);

  state_t              cur;
  state_t              nxt;
  logic                fail_q;
  logic                fail_d;
  logic                terr_d;
  logic [ITER_W-1:0]   iter_d;
  logic                hs;
  logic                tmo_tc;
  logic                tmo_clr;
  logic                abort;

  assign hs = (cur == S_RQST) || (cur == S_HOLD) ||
              (cur == S_RELEASE);

  // Illegal writer status is handled exactly like a timeout.
  assign abort = (hs && tmo_tc) ||
                 ((hs || cur == S_DECODE) &&
                  wr.wr_busy == BUSY_ILL);

  assign tmo_clr = (nxt == S_RQST) && (cur != S_RQST);

  hs_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk  (sys_clk),
    .rstn (rstn),
    .clr  (tmo_clr),
    .en   (hs),
    .tc   (tmo_tc)
  );

  always_comb begin
    nxt    = cur;
    iter_d = iter_cnt;
    fail_d = fail_q;
    terr_d = timeout_err;
    if (abort) begin
      nxt    = S_TERM;
      fail_d = 1'b1;
      terr_d = 1'b1;
    end else begin
      unique case (cur)
        S_IDLE: begin
          if (decode_start) begin
            nxt    = S_RQST;
            iter_d = '0;
            fail_d = 1'b0;
            terr_d = 1'b0;
          end
        end
        S_RQST: begin
          unique case (1'b1)
            wr.wr_busy == BUSY_LOAD: nxt = S_HOLD;
            wr.wr_busy == BUSY_FIN:  nxt = S_RELEASE;
            default:                 nxt = S_RQST;
          endcase
        end
        S_HOLD: begin
          if (wr.wr_busy == BUSY_FIN)
            nxt = S_RELEASE;
        end
        S_RELEASE: begin
          if (wr.wr_busy == BUSY_IDLE)
            nxt = S_DECODE;
        end
        S_DECODE: begin
          if (syndrome_valid) begin
            if (syndrome_pass) begin
              nxt    = S_TERM;
              fail_d = 1'b0;
            end else begin
              if (iter_cnt != ITER_W'(MAX_ITER))
                iter_d = iter_cnt + ITER_W'(1);
              if (iter_cnt >= ITER_W'(MAX_ITER - 1)) begin
                nxt    = S_TERM;
                fail_d = 1'b1;
              end else begin
                nxt = S_RQST;
              end
            end
          end
        end
        S_TERM:  nxt = S_DONE;
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      cur         <= S_IDLE;
      iter_cnt    <= '0;
      fail_q      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cur         <= nxt;
      iter_cnt    <= iter_d;
      fail_q      <= fail_d;
      timeout_err <= terr_d;
    end
  end

  assign wr.iter_rqst        = (cur == S_RQST) || (cur == S_HOLD);
  assign wr.iter_termination = (cur == S_TERM);
  assign decode_done         = (cur == S_DONE) && !fail_q;
  assign decode_fail         = (cur == S_DONE) && fail_q;
  assign state               = cur;

endmodule

// File: tb/tb_dnu_iter_rqst_fsm.sv
// tb_dnu_iter_rqst_fsm: writer BFM plus outcome model derived from
// per-codeword verdict sequences; checks timing and results.
module tb_dnu_iter_rqst_fsm;

  localparam int MAXI = 3;
  localparam int TMO  = 80;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RQST = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_REL  = 3'd3;
  localparam logic [2:0] ST_DEC  = 3'd4;
  localparam logic [2:0] ST_TERM = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  logic       sys_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       decode_start = 1'b0;
  logic       syndrome_valid = 1'b0;
  logic       syndrome_pass = 1'b0;
  logic [1:0] iter_cnt;
  logic       decode_done;
  logic       decode_fail;
  logic       timeout_err;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int rq_rises = 0;
  logic rq_prev = 1'b0;

  dnu_iter_rqst_fsm_if wr();

  dnu_iter_rqst_fsm #(
    .MAX_ITER (MAXI),
    .TIMEOUT  (TMO)
  ) dut (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .decode_start   (decode_start),
    .syndrome_valid (syndrome_valid),
    .syndrome_pass  (syndrome_pass),
    .wr             (wr),
    .iter_cnt       (iter_cnt),
    .decode_done    (decode_done),
    .decode_fail    (decode_fail),
    .timeout_err    (timeout_err),
    .state          (state)
  );

  always #5 sys_clk = ~sys_clk;

  // state, rqst, term, done, fail, terr, iter_cnt
  logic [9:0] obs;
  assign obs = {state, wr.iter_rqst, wr.iter_termination,
                decode_done, decode_fail, timeout_err, iter_cnt};

  always @(posedge sys_clk) begin
    rq_prev <= wr.iter_rqst;
    if (wr.iter_rqst && !rq_prev)
      rq_rises <= rq_rises + 1;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_handshake(input int it, input int d0,
                              input int len, input int d1,
                              input bit skip, input bit spur);
    logic [9:0] e;
    e = {ST_RQST, 5'b10000, 2'(it)};
    for (int k = 0; k < d0; k++) begin
      step();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rqst_wait: got %b want %b", obs, e);
      end
    end
    if (!skip) begin
      wr.wr_busy = 2'b01;
      e = {ST_HOLD, 5'b10000, 2'(it)};
      for (int k = 0; k < len; k++) begin
        if (spur && k == len / 2) begin
          syndrome_valid = 1'b1;
          syndrome_pass  = 1'b1;
        end
        step();
        syndrome_valid = 1'b0;
        syndrome_pass  = 1'b0;
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL hold: got %b want %b", obs, e);
        end
      end
    end
    wr.wr_busy = 2'b10;
    step();
    e = {ST_REL, 5'b00000, 2'(it)};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL release: got %b want %b", obs, e);
    end
    for (int k = 0; k < d1; k++) begin
      step();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL release_wait: got %b want %b", obs, e);
      end
    end
    wr.wr_busy = 2'b00;
    step();
    e = {ST_DEC, 5'b00000, 2'(it)};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL decode_entry: got %b want %b", obs, e);
    end
  endtask

  // pass_idx >= MAXI means the codeword never converges.
  // skip_mode: 0 writer loads, 1 jumps straight to 10, 2 random.
  task automatic run_codeword(input int pass_idx, input int fix_len,
                              input int skip_mode);
    logic [9:0] e;
    bit   exp_ok;
    int   exp_iter;
    int   exp_hs;
    int   rises0;
    bit   fin;
    int   len, d0, d1, d2;
    bit   skip;
    exp_ok   = (pass_idx < MAXI);
    exp_iter = exp_ok ? pass_idx : MAXI;
    exp_hs   = exp_ok ? pass_idx + 1 : MAXI;
    rises0   = rq_rises;
    fin      = 1'b0;
    decode_start = 1'b1;
    step();
    decode_start = 1'b0;
    e = {ST_RQST, 5'b10000, 2'b00};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL start: got %b want %b", obs, e);
    end
    for (int it = 0; it < MAXI && !fin; it++) begin
      len  = (fix_len > 0) ? fix_len : int'($urandom_range(1, 20));
      d0   = (fix_len > 0) ? 0 : int'($urandom_range(0, 3));
      d1   = (fix_len > 0) ? 0 : int'($urandom_range(0, 3));
      skip = (skip_mode == 1) ||
             (skip_mode == 2 && $urandom_range(0, 3) == 0);
      do_handshake(it, d0, len, d1, skip, 1'($urandom_range(0, 1)));
      d2 = int'($urandom_range(0, 3));
      e  = {ST_DEC, 5'b00000, 2'(it)};
      for (int k = 0; k < d2; k++) begin
        decode_start  = (k == 0);
        syndrome_pass = 1'($urandom_range(0, 1));
        step();
        decode_start  = 1'b0;
        syndrome_pass = 1'b0;
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL decode_wait: got %b want %b", obs, e);
        end
      end
      syndrome_valid = 1'b1;
      syndrome_pass  = (it == pass_idx);
      step();
      syndrome_valid = 1'b0;
      syndrome_pass  = 1'b0;
      if (it == pass_idx || it == MAXI - 1) begin
        fin = 1'b1;
        e = {ST_TERM, 5'b01000, 2'(exp_iter)};
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL term: got %b want %b", obs, e);
        end
      end else begin
        e = {ST_RQST, 5'b10000, 2'(it + 1)};
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL next_rqst: got %b want %b", obs, e);
        end
      end
    end
    step();
    e = {ST_DONE, 2'b00, exp_ok, !exp_ok, 1'b0, 2'(exp_iter)};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL outcome: got %b want %b", obs, e);
    end
    step();
    e = {ST_IDLE, 5'b00000, 2'(exp_iter)};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL back_idle: got %b want %b", obs, e);
    end
    n_checks++;
    if (rq_rises - rises0 !== exp_hs) begin
      n_fail++;
      $display("FAIL handshakes: got %0d want %0d",
               rq_rises - rises0, exp_hs);
    end
  endtask

  task automatic test_reset();
    rstn         = 1'b0;
    decode_start = 1'b1;
    wr.wr_busy   = 2'b00;
    step();
    step();
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", obs, 10'b0);
    end
    decode_start = 1'b0;
    rstn = 1'b1;
    step();
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want %b", obs, 10'b0);
    end
  endtask

  task automatic test_pass_first();
    run_codeword(0, 64, 0);
  endtask

  task automatic test_max_iter_fail();
    run_codeword(MAXI, 0, 0);
  endtask

  task automatic test_direct_fin();
    run_codeword(1, 0, 1);
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    int k;
    decode_start = 1'b1;
    step();
    decode_start = 1'b0;
    wr.wr_busy = 2'b01;
    k = 0;
    while (!timeout_err && k < TMO + 20) begin
      step();
      k++;
    end
    n_checks++;
    if (k !== TMO) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d want %0d", k, TMO);
    end
    e = {ST_TERM, 5'b01001, 2'b00};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL timeout_term: got %b want %b", obs, e);
    end
    wr.wr_busy = 2'b00;
    step();
    e = {ST_DONE, 5'b00011, 2'b00};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL timeout_fail: got %b want %b", obs, e);
    end
    step();
    e = {ST_IDLE, 5'b00001, 2'b00};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL timeout_sticky: got %b want %b", obs, e);
    end
  endtask

  task automatic test_reset_hold();
    logic [9:0] e;
    decode_start = 1'b1;
    step();
    decode_start = 1'b0;
    e = {ST_RQST, 5'b10000, 2'b00};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b want %b", obs, e);
    end
    do_handshake(0, 1, 5, 1, 1'b0, 1'b1);
    syndrome_valid = 1'b1;
    step();
    syndrome_valid = 1'b0;
    wr.wr_busy = 2'b01;
    step();
    step();
    e = {ST_HOLD, 5'b10000, 2'b01};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL pre_reset_hold: got %b want %b", obs, e);
    end
    rstn = 1'b0;
    step();
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_in_hold: got %b want %b", obs, 10'b0);
    end
    rstn = 1'b1;
    wr.wr_busy = 2'b00;
    step();
    run_codeword(2, 0, 2);
  endtask

  task automatic test_illegal_busy();
    logic [9:0] e;
    decode_start = 1'b1;
    step();
    decode_start = 1'b0;
    wr.wr_busy = 2'b01;
    step();
    step();
    wr.wr_busy = 2'b11;
    step();
    e = {ST_TERM, 5'b01001, 2'b00};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL illegal_term: got %b want %b", obs, e);
    end
    wr.wr_busy = 2'b00;
    step();
    e = {ST_DONE, 5'b00011, 2'b00};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL illegal_fail: got %b want %b", obs, e);
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10; c++)
      run_codeword(int'($urandom_range(0, MAXI)), 0, 2);
  endtask

  task automatic test_back_to_back();
    run_codeword(2, 0, 2);
    run_codeword(0, 0, 2);
    run_codeword(MAXI, 0, 2);
  endtask

  initial begin
    wr.wr_busy = 2'b00;
    test_reset();
    test_pass_first();
    test_max_iter_fail();
    test_direct_fin();
    test_timeout();
    test_reset_hold();
    test_illegal_busy();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
